c17_response_checker: RTL and testbench
=======================================

# c17_response_checker

Downstream response-analysis stage for the C17V3 benchmark in fault-injection campaigns. Samples the two outputs (G6gat, G7gat) of the circuit under test against those of a fault-free golden copy fed with the same pattern. Counts mismatches per output, records the index of the first failing pattern, and compacts the DUT responses into a MISR signature. A start/run/done FSM bounds each campaign to a fixed number of patterns.

## Interface
Parameters:
- N_PATTERNS, 32: accepted samples per campaign; must be in 1..2^CNT_W-1.
- CNT_W, 16: width of the pattern counter, error counters and index outputs.
- SIG_W, 8: MISR width; minimum 2.
- MISR_POLY, 8'h1D: feedback taps, SIG_W bits wide.
- SIG_SEED, 8'hFF: MISR value loaded at campaign start.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle campaign start request.
- valid  in  1  a DUT/golden sample pair is present this cycle.
- dut_g6, dut_g7  in  1 each  C17V3 outputs under test.
- ref_g6, ref_g7  in  1 each  golden C17V3 outputs.
- busy  out  1  FSM in RUN.
- done  out  1  FSM in DONE; results are final.
- pass  out  1  done and both error counters zero.
- pat_cnt  out  CNT_W  samples accepted in the current campaign.
- err_cnt_g6, err_cnt_g7  out  CNT_W each  mismatch counts per output; saturate at all-ones.
- first_err_valid  out  1  at least one mismatch seen.
- first_err_idx  out  CNT_W  pat_cnt value, before increment, of the first mismatching sample.
- signature  out  SIG_W  MISR state.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE + start: clear pat_cnt, both err_cnt, first_err_valid and first_err_idx; load signature with SIG_SEED; go to RUN.
- DONE + start: same clear/load as above; go to RUN.
- RUN: start is ignored.
- Accepted sample: valid=1 while in RUN. Samples with valid=0, or in any other state, have no effect.
- Per accepted sample:
  - pat_cnt += 1.
  - err_cnt_g6 += (dut_g6 != ref_g6), saturating.
  - err_cnt_g7 += (dut_g7 != ref_g7), saturating.
  - If either output mismatches and first_err_valid=0: set first_err_valid and capture the current pat_cnt into first_err_idx.
  - MISR update: sig_next = (sig << 1) ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ {0…, dut_g7, dut_g6}, with dut_g6 in bit 0.
- Campaign end: the accepted sample that takes pat_cnt to N_PATTERNS moves the FSM to DONE on the same edge.
- DONE holds all results stable until start or rst.
- busy = (state==RUN). done = (state==DONE). pass = done & (err_cnt_g6==0) & (err_cnt_g7==0). All three are decoded from registered state and counters only.

## Timing
- Reset values: state IDLE; busy=0, done=0, pass=0; pat_cnt=0, err counts=0, first_err_valid=0, first_err_idx=0; signature=SIG_SEED.
- rst asserted mid-RUN aborts the campaign immediately, asynchronously, to the reset values above.
- Start latency: start high at edge k moves the FSM to RUN after edge k. A valid pulse in the start cycle is not accepted, even when restarting from DONE.
- Each accepted sample at edge k is reflected in all counters and signature after edge k. Latency is 1 cycle; throughput is one sample per cycle with no gaps required.
- done rises after the edge that accepts sample N_PATTERNS. Further valid pulses while in DONE are ignored.
- A counter already saturated stays at all-ones. pat_cnt never wraps, because N_PATTERNS is bounded.
- Simultaneous start and valid in DONE: the restart wins and the sample is dropped.

## Test plan
- Reset, then start, then 4 zero samples, all outputs matching (N_PATTERNS=4, SIG_SEED=0xFF, POLY=0x1D) -> signature steps E3, DB, AB, 4B; done=1, pass=1, pat_cnt=4.
- N_PATTERNS=32; dut_g7 inverted vs ref on samples 5 and 9 only -> err_cnt_g7=2, err_cnt_g6=0, first_err_idx=5, first_err_valid=1, pass=0.
- valid toggled 1,0,0,1 with start reasserted during RUN -> pat_cnt advances only on valid cycles; the start in RUN is ignored.
- Complete a campaign, then start together with valid in DONE -> all counters cleared, signature=SIG_SEED, pat_cnt=0 one cycle later, sample dropped.
- rst pulsed mid-RUN after 10 samples -> outputs return to reset values without waiting for a clock edge; the next start runs a fresh campaign.
- CNT_W=2, N_PATTERNS=3, dut_g6 mismatching on every sample -> err_cnt_g6 reaches 3 (all-ones) and holds; done after 3 samples.

Source files
------------

// File: rtl/c17_response_checker.sv
// Response checker for the C17V3 fault-injection harness.
// Compares DUT outputs G6/G7 against a golden copy, counts mismatches per
// output, latches the index of the first failing pattern, and folds the DUT
// responses into a MISR signature. A campaign runs IDLE -> RUN -> DONE and
// stops after N_PATTERNS accepted samples.
module c17_response_checker #(
    parameter int               N_PATTERNS = 32,
    parameter int               CNT_W      = 16,
    parameter int               SIG_W      = 8,
    parameter logic [SIG_W-1:0] MISR_POLY  = 8'h1D,
    parameter logic [SIG_W-1:0] SIG_SEED   = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic             dut_g6,
    input  logic             dut_g7,
    input  logic             ref_g6,
    input  logic             ref_g7,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pat_cnt,
    output logic [CNT_W-1:0] err_cnt_g6,
    output logic [CNT_W-1:0] err_cnt_g7,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Value of pat_cnt when the final sample of a campaign is accepted.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PATTERNS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   pat_cnt_q, pat_cnt_d;
    logic [CNT_W-1:0]   err_g6_q, err_g6_d;
    logic [CNT_W-1:0]   err_g7_q, err_g7_d;
    logic               fev_q, fev_d;
    logic [CNT_W-1:0]   fidx_q, fidx_d;
    logic [SIG_W-1:0]   sig_q, sig_d;

    logic               mis_g6, mis_g7;
    logic [SIG_W-1:0]   misr_next;

    assign mis_g6 = dut_g6 ^ ref_g6;
    assign mis_g7 = dut_g7 ^ ref_g7;

    // MISR step: shift left, fold MSB through the taps, inject {g7,g6}.
    always_comb begin
        misr_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
                  ^ SIG_W'({dut_g7, dut_g6});
    end

    // Campaign FSM and per-sample bookkeeping; start only acts outside RUN.
    always_comb begin
        state_d   = state_q;
        pat_cnt_d = pat_cnt_q;
        err_g6_d  = err_g6_q;
        err_g7_d  = err_g7_q;
        fev_d     = fev_q;
        fidx_d    = fidx_q;
        sig_d     = sig_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A sample arriving with start is dropped: the restart wins.
                if (start) begin
                    pat_cnt_d = '0;
                    err_g6_d  = '0;
                    err_g7_d  = '0;
                    fev_d     = 1'b0;
                    fidx_d    = '0;
                    sig_d     = SIG_SEED;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (valid) begin
                    pat_cnt_d = pat_cnt_q + 1'b1;
                    if (mis_g6 && (err_g6_q != '1)) err_g6_d = err_g6_q + 1'b1;
                    if (mis_g7 && (err_g7_q != '1)) err_g7_d = err_g7_q + 1'b1;
                    if ((mis_g6 || mis_g7) && !fev_q) begin
                        fev_d  = 1'b1;
                        fidx_d = pat_cnt_q;
                    end
                    sig_d = misr_next;
                    if (pat_cnt_q == LAST_IDX) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset aborts any campaign immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_cnt_q <= '0;
            err_g6_q  <= '0;
            err_g7_q  <= '0;
            fev_q     <= 1'b0;
            fidx_q    <= '0;
            sig_q     <= SIG_SEED;
        end else begin
            state_q   <= state_d;
            pat_cnt_q <= pat_cnt_d;
            err_g6_q  <= err_g6_d;
            err_g7_q  <= err_g7_d;
            fev_q     <= fev_d;
            fidx_q    <= fidx_d;
            sig_q     <= sig_d;
        end
    end

    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign pass            = done && (err_g6_q == '0) && (err_g7_q == '0);
    assign pat_cnt         = pat_cnt_q;
    assign err_cnt_g6      = err_g6_q;
    assign err_cnt_g7      = err_g7_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fidx_q;
    assign signature       = sig_q;

endmodule

// File: tb/tb_c17_response_checker.sv
// Scoreboard bench for c17_response_checker. Two instances share stimulus:
// a default-sized one (N=32) and a tiny one (CNT_W=2, N=3, SIG_W=2) that
// exercises counter saturation and the minimum MISR width.
module tb_c17_response_checker;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0;
    logic dut_g6 = 1'b0, dut_g7 = 1'b0, ref_g6 = 1'b0, ref_g7 = 1'b0;

    always #5 clk = ~clk;

    logic        a_busy, a_done, a_pass, a_fev;
    logic [15:0] a_pat, a_e6, a_e7, a_fidx;
    logic [7:0]  a_sig;
    logic        b_busy, b_done, b_pass, b_fev;
    logic [1:0]  b_pat, b_e6, b_e7, b_fidx;
    logic [1:0]  b_sig;

    c17_response_checker u_a (
        .clk(clk), .rst(rst), .start(start), .valid(valid),
        .dut_g6(dut_g6), .dut_g7(dut_g7), .ref_g6(ref_g6), .ref_g7(ref_g7),
        .busy(a_busy), .done(a_done), .pass(a_pass), .pat_cnt(a_pat),
        .err_cnt_g6(a_e6), .err_cnt_g7(a_e7), .first_err_valid(a_fev),
        .first_err_idx(a_fidx), .signature(a_sig)
    );

    c17_response_checker #(
        .N_PATTERNS(3), .CNT_W(2), .SIG_W(2), .MISR_POLY(2'h3), .SIG_SEED(2'h1)
    ) u_b (
        .clk(clk), .rst(rst), .start(start), .valid(valid),
        .dut_g6(dut_g6), .dut_g7(dut_g7), .ref_g6(ref_g6), .ref_g7(ref_g7),
        .busy(b_busy), .done(b_done), .pass(b_pass), .pat_cnt(b_pat),
        .err_cnt_g6(b_e6), .err_cnt_g7(b_e7), .first_err_valid(b_fev),
        .first_err_idx(b_fidx), .signature(b_sig)
    );

    // Reference model: campaign phase 0=idle 1=running 2=finished.
    typedef struct { int npat; int cmax; int sigw; int poly; int seed; } cfg_t;
    typedef struct { int phase; int pat; int e6; int e7; int fev; int fidx; int sig; } mdl_t;
    typedef struct { mdl_t a; mdl_t b; } exp_t;

    cfg_t ca, cb;
    mdl_t ma, mb;
    exp_t q[$];
    int   total = 0, bad = 0;

    function automatic mdl_t mreset(cfg_t c);
        mdl_t m;
        m.phase = 0; m.pat = 0; m.e6 = 0; m.e7 = 0; m.fev = 0; m.fidx = 0;
        m.sig = c.seed;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m0, cfg_t c, int st, int v, int d6, int d7, int r6, int r7);
        mdl_t m = m0;
        int fb;
        if (m.phase != 1) begin
            if (st != 0) begin
                m = mreset(c);
                m.phase = 1;
            end
            return m;
        end
        if (v == 0) return m;
        if ((d6 != r6 || d7 != r7) && m.fev == 0) begin
            m.fev = 1;
            m.fidx = m.pat;
        end
        if (d6 != r6 && m.e6 < c.cmax) m.e6 = m.e6 + 1;
        if (d7 != r7 && m.e7 < c.cmax) m.e7 = m.e7 + 1;
        fb = (m.sig >> (c.sigw - 1)) & 1;
        m.sig = ((m.sig * 2) % (1 << c.sigw)) ^ (fb != 0 ? c.poly : 0) ^ (d7 * 2 + d6);
        m.pat = m.pat + 1;
        if (m.pat == c.npat) m.phase = 2;
        return m;
    endfunction

    task automatic chk(string nm, int act, int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic cmp_dut(string tag, mdl_t m, int busy, int done, int pass, int pat,
                           int e6, int e7, int fev, int fidx, int sig);
        int md;
        md = (m.phase == 2) ? 1 : 0;
        chk({tag, ".busy"}, busy, (m.phase == 1) ? 1 : 0);
        chk({tag, ".done"}, done, md);
        chk({tag, ".pass"}, pass, (md == 1 && m.e6 == 0 && m.e7 == 0) ? 1 : 0);
        chk({tag, ".pat_cnt"}, pat, m.pat);
        chk({tag, ".err_g6"}, e6, m.e6);
        chk({tag, ".err_g7"}, e7, m.e7);
        chk({tag, ".first_err_valid"}, fev, m.fev);
        chk({tag, ".first_err_idx"}, fidx, m.fidx);
        chk({tag, ".signature"}, sig, m.sig);
    endtask

    task automatic cmp_both(string tag, mdl_t xa, mdl_t xb);
        cmp_dut({tag, "_a"}, xa, a_busy, a_done, a_pass, a_pat, a_e6, a_e7, a_fev, a_fidx, a_sig);
        cmp_dut({tag, "_b"}, xb, b_busy, b_done, b_pass, b_pat, b_e6, b_e7, b_fev, b_fidx, b_sig);
    endtask

    // Monitor: every clock edge produces one expected snapshot; compare it
    // half a cycle later, once the DUT registers have settled.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp_both("mon", e.a, e.b);
        end
    end

    // Drive one cycle of stimulus; update the model at the edge and queue it.
    task automatic cyc(int st, int v, int d6, int d7, int r6, int r7);
        exp_t e;
        start = st[0]; valid = v[0];
        dut_g6 = d6[0]; dut_g7 = d7[0]; ref_g6 = r6[0]; ref_g7 = r7[0];
        @(posedge clk);
        ma = mstep(ma, ca, st, v, d6, d7, r6, r7);
        mb = mstep(mb, cb, st, v, d6, d7, r6, r7);
        e.a = ma; e.b = mb;
        q.push_back(e);
        #1;
    endtask

    initial begin
        int steps [4];
        int vp [4];
        int sp [4];
        int idx, k, v, st, r6, r7, d6, d7;
        steps[0] = 'hE3; steps[1] = 'hDB; steps[2] = 'hAB; steps[3] = 'h4B;
        vp[0] = 1; vp[1] = 0; vp[2] = 0; vp[3] = 1;
        sp[0] = 0; sp[1] = 1; sp[2] = 1; sp[3] = 0;
        ca.npat = 32; ca.cmax = 65535; ca.sigw = 8; ca.poly = 'h1D; ca.seed = 'hFF;
        cb.npat = 3;  cb.cmax = 3;     cb.sigw = 2; cb.poly = 3;     cb.seed = 1;
        ma = mreset(ca); mb = mreset(cb);

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        cmp_both("reset", ma, mb);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);

        // Start with a sample in the same cycle: that sample is dropped.
        cyc(1, 1, 0, 0, 0, 0);
        chk("start_pat_zero", a_pat, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            chk("sig_step", a_sig, steps[i]);
        end

        // Rest of the 32-pattern campaign; g7 flipped on patterns 5 and 9.
        // The first four cycles force valid 1,0,0,1 with start raised in RUN.
        idx = 4; k = 0;
        while (idx < 32) begin
            v  = (k < 4) ? vp[k] : (($urandom_range(0, 3) != 0) ? 1 : 0);
            st = (k < 4) ? sp[k] : (($urandom_range(0, 7) == 0) ? 1 : 0);
            r6 = $urandom_range(0, 1); r7 = $urandom_range(0, 1);
            d6 = r6;
            d7 = r7 ^ ((v == 1 && (idx == 5 || idx == 9)) ? 1 : 0);
            cyc(st, v, d6, d7, r6, r7);
            if (v == 1) idx++;
            if (k == 3) chk("gap_pat_cnt", a_pat, 6);
            k++;
        end
        chk("c1_done", a_done, 1);
        chk("c1_err_g7", a_e7, 2);
        chk("c1_err_g6", a_e6, 0);
        chk("c1_first_idx", a_fidx, 5);
        chk("c1_first_valid", a_fev, 1);
        chk("c1_pass", a_pass, 0);

        // Samples in DONE are ignored; then start+valid restarts cleanly.
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        chk("done_hold_pat", a_pat, 32);
        cyc(1, 1, 1, 1, 0, 0);
        chk("restart_pat", a_pat, 0);
        chk("restart_sig", a_sig, 'hFF);
        chk("restart_err", a_e7, 0);
        chk("restart_busy", a_busy, 1);

        // Ten samples, then an asynchronous reset away from any clock edge.
        for (int i = 0; i < 10; i++)
            cyc(0, 1, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1));
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        ma = mreset(ca); mb = mreset(cb);
        cmp_both("async_rst", ma, mb);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fresh campaign with g6 wrong on every sample.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            r6 = $urandom_range(0, 1); r7 = $urandom_range(0, 1);
            cyc(0, 1, r6 ^ 1, r7, r6, r7);
            if (i == 2) begin
                chk("sat_err_g6", b_e6, 3);
                chk("sat_done", b_done, 1);
            end
        end
        chk("sat_hold", b_e6, 3);
        chk("c3_err_g6", a_e6, 32);
        chk("c3_done", a_done, 1);

        // Random traffic including occasional restarts.
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 19) == 0) ? 1 : 0, ($urandom_range(0, 9) < 7) ? 1 : 0,
                $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1));

        start = 1'b0; valid = 1'b0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
